// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, asynchronous-ROM addressing and the IF/ID register,
// delivered to decode over valid/ready, with redirect from execute and halt-on-EBREAK.
module instr_fetch #(
    parameter int unsigned ANCHO      = 32,
    parameter int unsigned LARGO      = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'h0010_0073,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    localparam int unsigned AW        = $clog2(LARGO)
) (
    input  logic             CLK,
    input  logic             RST_n,
    output logic [AW-1:0]    rom_addr,
    input  logic [ANCHO-1:0] rom_dout,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [ANCHO-1:0] id_instr,
    output logic [31:0]      id_pc,
    output logic             halted,
    output logic             misaligned
);

    localparam logic [ANCHO-1:0] HaltWord = ANCHO'(HALT_INSTR);
    localparam logic [ANCHO-1:0] NopWord  = ANCHO'(NOP_INSTR);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        slot_free;
    logic        is_halt;

    // Word address comes from the current pc; upper pc bits fold the ROM modulo LARGO.
    assign rom_addr  = pc[AW+1:2];
    assign pc_plus4  = pc + 32'd4;
    assign slot_free = !id_valid || id_ready;
    assign is_halt   = (rom_dout == HaltWord);

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state      <= StBoot;
            pc         <= RESET_PC;
            id_valid   <= 1'b0;
            id_instr   <= NopWord;
            id_pc      <= 32'h0;
            halted     <= 1'b0;
            misaligned <= 1'b0;
        end else if (redirect) begin
            // A transfer completing this cycle is unaffected; only the next slot is flushed.
            state      <= StRun;
            pc         <= redirect_pc & ~32'h3;
            id_valid   <= 1'b0;
            id_instr   <= NopWord;
            halted     <= 1'b0;
            misaligned <= |redirect_pc[1:0];
        end else begin
            misaligned <= 1'b0;
            unique case (state)
                StBoot: begin
                    state <= StRun;
                end
                StRun: begin
                    if (slot_free) begin
                        id_valid <= 1'b1;
                        id_instr <= rom_dout;
                        id_pc    <= pc;
                        if (is_halt) begin
                            state  <= StHalt;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end
                StHalt: begin
                    if (id_valid && id_ready) begin
                        id_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= StBoot;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: boot latency, stall, redirect, misalignment, halt,
// reset priority, and address wrap on a 16-word ROM.
module tb_instr_fetch;

    localparam logic [31:0] Halt = 32'h0010_0073;
    localparam logic [31:0] Nop  = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic [9:0]  rom_addr;
    logic [31:0] rom_dout;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;
    logic        misaligned;

    logic        rst_n_b;
    logic        redirect_b;
    logic [31:0] redirect_pc_b;
    logic [3:0]  rom_addr_b;
    logic [31:0] rom_dout_b;
    logic        id_valid_b;
    logic [31:0] id_instr_b;
    logic [31:0] id_pc_b;
    logic        halted_b;
    logic        misaligned_b;

    logic [31:0] rom   [1024];
    logic [31:0] rom16 [16];

    int n_checks = 0;
    int n_fail   = 0;

    assign rom_dout   = rom[rom_addr];
    assign rom_dout_b = rom16[rom_addr_b];

    instr_fetch dut (
        .CLK        (clk),
        .RST_n      (rst_n),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .halted     (halted),
        .misaligned (misaligned)
    );

    instr_fetch #(.LARGO(16)) dut_small (
        .CLK        (clk),
        .RST_n      (rst_n_b),
        .rom_addr   (rom_addr_b),
        .rom_dout   (rom_dout_b),
        .redirect   (redirect_b),
        .redirect_pc(redirect_pc_b),
        .id_ready   (1'b1),
        .id_valid   (id_valid_b),
        .id_instr   (id_instr_b),
        .id_pc      (id_pc_b),
        .halted     (halted_b),
        .misaligned (misaligned_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_id(input string tag, input logic v, input logic [31:0] pc_e,
                             input logic [31:0] instr_e);
        check({tag, "_valid"}, 32'(id_valid), 32'(v));
        check({tag, "_pc"}, id_pc, pc_e);
        check({tag, "_instr"}, id_instr, instr_e);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) rom[k] = k + 1;
        for (int k = 0; k < 16; k++) rom16[k] = 32'h100 + k;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        rst_n_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = 32'h0;

        tick(); tick();
        expect_id("reset", 1'b0, 32'h0, Nop);
        check("reset_halted", 32'(halted), 32'h0);
        check("reset_misaligned", 32'(misaligned), 32'h0);
        check("reset_rom_addr", 32'(rom_addr), 32'h0);

        // Boot: first edge only leaves BOOT, second captures ROM[0].
        rst_n = 1'b1;
        tick();
        check("boot_valid", 32'(id_valid), 32'h0);
        tick(); expect_id("run0", 1'b1, 32'h0, 32'd1);
        tick(); expect_id("run1", 1'b1, 32'h4, 32'd2);
        tick(); expect_id("run2", 1'b1, 32'h8, 32'd3);

        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_id("stall", 1'b1, 32'h8, 32'd3);
            check("stall_rom_addr", 32'(rom_addr), 32'd3);
        end
        id_ready = 1'b1;
        tick(); expect_id("resume", 1'b1, 32'hC, 32'd4);

        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        expect_id("flush", 1'b0, 32'hC, Nop);
        check("flush_misaligned", 32'(misaligned), 32'h0);
        redirect = 1'b0;
        tick(); expect_id("redir0", 1'b1, 32'h40, 32'd17);
        tick(); expect_id("redir1", 1'b1, 32'h44, 32'd18);

        redirect = 1'b1; redirect_pc = 32'h43;
        tick();
        check("misal_pulse", 32'(misaligned), 32'h1);
        check("misal_valid", 32'(id_valid), 32'h0);
        check("misal_rom_addr", 32'(rom_addr), 32'd16);
        redirect = 1'b0;
        tick();
        check("misal_clear", 32'(misaligned), 32'h0);
        expect_id("misal_fetch", 1'b1, 32'h40, 32'd17);

        rom[5] = Halt;
        redirect = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect = 1'b0;
        tick(); expect_id("pre_halt", 1'b1, 32'h10, 32'd5);
        check("pre_halt_halted", 32'(halted), 32'h0);
        tick(); expect_id("halt_word", 1'b1, 32'h14, Halt);
        check("halt_flag", 32'(halted), 32'h1);
        tick();
        check("halt_drain_valid", 32'(id_valid), 32'h0);
        check("halt_drain_halted", 32'(halted), 32'h1);
        tick();
        check("halt_idle_valid", 32'(id_valid), 32'h0);
        check("halt_rom_addr", 32'(rom_addr), 32'd5);

        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        check("unhalt_halted", 32'(halted), 32'h0);
        check("unhalt_valid", 32'(id_valid), 32'h0);
        redirect = 1'b0;
        tick(); expect_id("restart", 1'b1, 32'h0, 32'd1);

        // Reset wins over a simultaneous misaligned redirect.
        rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h83;
        tick();
        expect_id("rst_prio", 1'b0, 32'h0, Nop);
        check("rst_prio_misal", 32'(misaligned), 32'h0);
        check("rst_prio_rom_addr", 32'(rom_addr), 32'h0);
        redirect = 1'b0; rst_n = 1'b1;

        rst_n_b = 1'b1;
        tick(); tick();
        redirect_b = 1'b1; redirect_pc_b = 32'h3C;
        tick();
        check("wrap_addr15", 32'(rom_addr_b), 32'd15);
        redirect_b = 1'b0;
        tick();
        check("wrap_pc3c", id_pc_b, 32'h3C);
        check("wrap_instr15", id_instr_b, 32'h10F);
        check("wrap_addr0", 32'(rom_addr_b), 32'd0);
        tick();
        check("wrap_pc40", id_pc_b, 32'h40);
        check("wrap_instr0", id_instr_b, 32'h100);
        check("wrap_valid", 32'(id_valid_b), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
